mem_reg_bridge: RTL and testbench
=================================

// Module: mem_reg_bridge
// PURPOSE
//  Upstream port adapter between a core-side memory request interface (valid/ready, 4-bit byte strobes)
//  and the mem_reg word RAM (1-cycle registered read, word-only write).
//  - Serialises one request at a time.
//  - Performs read-modify-write for partial-strobe stores; mem_reg has no byte enables.
//  - Range-checks addresses against MEM_SIZE.
// PARAMETERS
//  MEM_SIZE    4096  bytes in the attached mem_reg; must match its MEM_SIZE; power of 2, >= 8
//  ADDR_WIDTH  32    address width on both sides
//  DATA_WIDTH  32    data width; fixed at 32 (4 byte lanes)
// PORTS
//  clk        in   1   single clock for bridge and mem_reg
//  resetn     in   1   asynchronous, active-low reset
//  mem_valid  in   1   request valid; held until mem_ready
//  mem_addr   in   32  byte address; bits [1:0] ignored (word aligned)
//  mem_wdata  in   32  store data; lane i = bits [8i+7:8i]
//  mem_wstrb  in   4   byte strobes; 4'b0000 = read
//  mem_ready  out  1   one-cycle response pulse
//  mem_rdata  out  32  read data, valid while mem_ready=1
//  mem_err    out  1   out-of-range flag, valid while mem_ready=1
//  we_A       out  1   mem_reg write enable
//  addr_A     out  32  mem_reg read address
//  addw_A     out  32  mem_reg write address (always equal to addr_A)
//  din_A      out  32  mem_reg write data
//  dout_A     in   32  mem_reg read data; valid the cycle after addr_A is presented
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (mem_ready, mem_err, we_A, addr_A, addw_A, din_A, mem_rdata).
//   Reset mid-operation aborts the request with no write and no response.
//  FSM states: IDLE, RD_ISSUE, RD_WAIT, WRITE, RESP. All outputs are registered or decoded from state.
//  IDLE
//   - On mem_valid: latch addr as {mem_addr[ADDR_WIDTH-1:2],2'b00}, plus wdata and wstrb.
//   - Out of range (mem_addr >= MEM_SIZE): go to RESP with err=1; no mem_reg access.
//   - Else wstrb==4'b1111: go to WRITE.
//   - Else (read or partial write): go to RD_ISSUE.
//  RD_ISSUE: addr_A = latched addr (mem_reg samples at the end of this cycle); go to RD_WAIT.
//  RD_WAIT: dout_A is valid.
//   - Read: rdata_q <= dout_A; go to RESP.
//   - Partial write: wdata_q lane i <= wstrb[i] ? wdata lane i : dout_A lane i; go to WRITE.
//  WRITE: we_A=1 for exactly this one cycle; din_A = wdata_q; addw_A = addr_A; go to RESP.
//  RESP: mem_ready=1 for one cycle.
//   - mem_rdata = rdata_q for reads, 0 for writes and errors.
//   - mem_err = err.
//   - Go to IDLE. A new request is not accepted in the RESP cycle.
//  Latency (mem_valid seen in IDLE at cycle 0 -> mem_ready high):
//   - read: cycle 3
//   - full write: cycle 2
//   - partial write: cycle 4
//   - error: cycle 1
//  we_A is never high outside WRITE. No write ever occurs for reads, errors, or wstrb=0.
//  Inputs are sampled only in IDLE; changes to mem_* after acceptance are ignored.
//   Dropping mem_valid before mem_ready is a protocol violation; the bridge still completes.
//  Address wrap: none. Every address >= MEM_SIZE errors, including 0xFFFF_FFFC.
//  Back-to-back requests: one response at most every 2 cycles (RESP -> IDLE -> accept).
// TESTING
//  1 Reset: resetn=0 mid-read (RD_WAIT) -> we_A=0 and mem_ready=0 throughout; after release, next request works normally.
//  2 Full write then read: write addr 0x10 data 0xDEADBEEF strb 4'hF -> ready at +2, one we_A pulse;
//    read 0x10 -> ready at +3, rdata=0xDEADBEEF, err=0.
//  3 Partial write RMW: word 0x20 = 0x11223344; write 0xAABBCCDD strb 4'b0101 -> ready at +4;
//    read back 0x11BB33DD.
//  4 Range: read 0x1000 (MEM_SIZE=4096) -> ready at +1, err=1, rdata=0, we_A never asserted;
//    write 0xFFC -> succeeds, err=0.
//  5 Unaligned/empty strobe: write 0x32 strb 4'h0 -> treated as a read of 0x30, no we_A;
//    mem_addr[1:0] ignored on a full write to 0x33 -> data lands at word 0x30.
//  6 Back-to-back: 8 alternating writes/reads with mem_valid held high -> each response matches the
//    scoreboard model; exactly one mem_ready pulse per request.

Source files
------------

// File: rtl/mem_reg_bridge.sv
// mem_reg_bridge: adapts a valid/ready byte-strobed core memory port onto the
// mem_reg word RAM (1-cycle registered read, word-only write). Serialises one
// request at a time, does read-modify-write for partial stores, and flags
// addresses at or beyond MEM_SIZE.
//
// Core-side handshake: the core raises mem_valid with mem_addr/mem_wdata/
// mem_wstrb stable and holds them until mem_ready. mem_ready is a single-cycle
// pulse; mem_rdata and mem_err are meaningful only while mem_ready is high.
// Inputs are sampled only in IDLE, so a response cycle never accepts.
module mem_reg_bridge #(
  parameter int MEM_SIZE   = 4096,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mem_valid,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_err,
  output logic                  we_A,
  output logic [ADDR_WIDTH-1:0] addr_A,
  output logic [ADDR_WIDTH-1:0] addw_A,
  output logic [DATA_WIDTH-1:0] din_A,
  input  logic [DATA_WIDTH-1:0] dout_A,
  output logic [2:0]            dbg_state
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_ISSUE = 3'd1;
  localparam logic [2:0] RD_WAIT  = 3'd2;
  localparam logic [2:0] WRITE    = 3'd3;
  localparam logic [2:0] RESP     = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_SIZE);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  err_q,   err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Next-state and datapath: latch the request in IDLE, merge RAM data into
  // unstrobed lanes in RD_WAIT so WRITE always stores a full word.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          addr_d  = {mem_addr[ADDR_WIDTH-1:2], 2'b00};
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          err_d   = 1'b0;
          if (mem_addr >= MEM_LIMIT) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (mem_wstrb == 4'hF) begin
            state_d = WRITE;
          end else begin
            state_d = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        if (wstrb_q == 4'h0) begin
          rdata_d = dout_A;
          state_d = RESP;
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (!wstrb_q[i]) wdata_d[8*i +: 8] = dout_A[8*i +: 8];
          end
          state_d = WRITE;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and request registers; reset aborts any request in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs are either registers or pure decodes of the current state.
  always_comb begin
    mem_ready = (state_q == RESP);
    mem_err   = (state_q == RESP) && err_q;
    mem_rdata = ((state_q == RESP) && !err_q && (wstrb_q == 4'h0)) ? rdata_q : '0;
    we_A      = (state_q == WRITE);
    addr_A    = addr_q;
    addw_A    = addr_q;
    din_A     = wdata_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_mem_reg_bridge.sv
// Bench for mem_reg_bridge: a behavioural mem_reg RAM on the far side and a
// word-array reference model of what the core should observe.
module tb_mem_reg_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        we_A;
  logic [31:0] addr_A;
  logic [31:0] addw_A;
  logic [31:0] din_A;
  logic [31:0] dout_A = '0;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  bit after_resp = 0;

  logic [31:0] ram     [0:1023] = '{default: '0};
  logic [31:0] ref_mem [0:1023] = '{default: '0};

  mem_reg_bridge #(.MEM_SIZE(4096), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_err(mem_err), .we_A(we_A), .addr_A(addr_A),
    .addw_A(addw_A), .din_A(din_A), .dout_A(dout_A), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Behavioural mem_reg: registered read, word write
  always @(posedge clk) begin
    if (we_A) ram[addw_A[11:2]] <= din_A;
    dout_A <= ram[addr_A[11:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Idle cycles with mem_valid low; nothing may pulse.
  task automatic idle(input int n);
    int bad = 0;
    mem_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (mem_ready || we_A) bad++;
    end
    check("idle_quiet", bad, 0);
    after_resp = 0;
  endtask

  // One request: reference expectations from the request rules, then drive
  // and measure latency, response, and RAM write activity.
  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input bit hold, output logic [31:0] rd_obs);
    int idx, lat_exp, lat, wes;
    bit err_exp, got, wr_exp;
    logic [31:0] rd_exp, wd_exp, old, we_val, we_addr, we_raddr;
    idx = int'(a[11:2]);
    err_exp = (a >= 32'd4096);
    rd_exp = '0; wd_exp = '0; wr_exp = 0;
    old = ref_mem[idx];
    if (err_exp) lat_exp = 1;
    else if (s == 4'h0) begin lat_exp = 3; rd_exp = old; end
    else begin
      lat_exp = (s == 4'hF) ? 2 : 4;
      wr_exp = 1;
      for (int b = 0; b < 4; b++) wd_exp[8*b +: 8] = s[b] ? d[8*b +: 8] : old[8*b +: 8];
      ref_mem[idx] = wd_exp;
    end
    if (after_resp) lat_exp++;

    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    lat = 0; wes = 0; got = 0; we_val = '0; we_addr = '0; we_raddr = '0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (we_A) begin wes++; we_val = din_A; we_addr = addw_A; we_raddr = addr_A; end
      if (mem_ready) begin got = 1; rd_obs = mem_rdata; end
    end
    check("ready_seen", 32'(got), 32'd1);
    check("latency", lat, lat_exp);
    check("rdata", mem_rdata, rd_exp);
    check("err", 32'(mem_err), 32'(err_exp));
    check("we_pulses", wes, 32'(wr_exp));
    if (wr_exp) begin
      check("din_A", we_val, wd_exp);
      check("addw_A", we_addr, {a[31:2], 2'b00});
      check("addw_eq_addr", we_addr, we_raddr);
    end
    if (!got) rd_obs = 'x;
    mem_valid = hold;
    after_resp = 1;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a, d;
    logic [3:0]  s;
    int bad;

    // Reset state
    #2;
    check("rst_ready", 32'(mem_ready), 0);
    check("rst_err", 32'(mem_err), 0);
    check("rst_we", 32'(we_A), 0);
    check("rst_addr_A", addr_A, 0);
    check("rst_addw_A", addw_A, 0);
    check("rst_din_A", din_A, 0);
    check("rst_rdata", mem_rdata, 0);
    @(negedge clk); resetn = 1'b1;
    idle(2);

    // Reset during RD_WAIT aborts with no write and no response
    mem_valid = 1'b1; mem_addr = 32'h40; mem_wdata = 32'hFFFF_FFFF; mem_wstrb = 4'b0011;
    repeat (2) begin @(posedge clk); #1; end
    resetn = 1'b0; mem_valid = 1'b0;
    #1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_ready || we_A) bad++;
      @(posedge clk); #1;
    end
    check("reset_abort_quiet", bad, 0);
    @(negedge clk); resetn = 1'b1;
    after_resp = 0;
    do_req(32'h40, 32'h0, 4'h0, 0, r);
    check("post_reset_read", r, 32'h0);
    idle(1);

    // Full write then read
    do_req(32'h10, 32'hDEADBEEF, 4'hF, 0, r);
    idle(1);
    do_req(32'h10, 32'h0, 4'h0, 0, r);
    check("read_10", r, 32'hDEADBEEF);
    idle(1);

    // Partial write RMW
    do_req(32'h20, 32'h11223344, 4'hF, 0, r);
    idle(1);
    do_req(32'h20, 32'hAABBCCDD, 4'b0101, 0, r);
    idle(1);
    do_req(32'h20, 32'h0, 4'h0, 0, r);
    check("rmw_20", r, 32'h11BB33DD);
    idle(1);

    // Range boundaries
    do_req(32'h1000, 32'h0, 4'h0, 0, r);
    idle(1);
    do_req(32'hFFFF_FFFC, 32'h12345678, 4'hF, 0, r);
    idle(1);
    do_req(32'hFFC, 32'hCAFEF00D, 4'hF, 0, r);
    idle(1);
    do_req(32'hFFC, 32'h0, 4'h0, 0, r);
    check("read_ffc", r, 32'hCAFEF00D);
    idle(1);

    // Empty strobe is a read; low address bits ignored
    do_req(32'h32, 32'h55555555, 4'h0, 0, r);
    idle(1);
    do_req(32'h33, 32'h0BADC0DE, 4'hF, 0, r);
    idle(1);
    do_req(32'h30, 32'h0, 4'h0, 0, r);
    check("read_30", r, 32'h0BADC0DE);
    idle(1);

    // Back-to-back alternating writes/reads with mem_valid held
    for (int i = 0; i < 8; i++) begin
      a = 32'h100 + 32'(i / 2) * 4;
      if (i % 2 == 0) begin
        s = (i % 4 == 0) ? 4'hF : 4'(($urandom_range(1, 14)));
        do_req(a, $urandom, s, 1, r);
      end else begin
        do_req(a, $urandom, 4'h0, (i < 7), r);
      end
    end
    idle(2);

    // Randomised traffic over a small address window plus out-of-range hits
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0)
        a = ($urandom_range(0, 1) == 0) ? 32'h1000 + 32'($urandom_range(0, 255)) : 32'hFFFF_FFFC;
      else
        a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      d = $urandom;
      case ($urandom_range(0, 2))
        0: s = 4'h0;
        1: s = 4'hF;
        default: s = 4'($urandom_range(0, 15));
      endcase
      do_req(a, d, s, ($urandom_range(0, 1) == 1), r);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(2);

    // RAM image must match the reference model
    bad = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) bad++;
    check("ram_image", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
